// File: rtl/er_cde_sequencer.sv
// er_cde_sequencer: arbitrates error requesters into a queue and rotates queued codes onto the ER_CDE display bus
module er_cde_sequencer #(
  parameter int NSRC      = 2,
  parameter int DEPTH     = 4,
  parameter int HOLD_CYC  = 8,
  parameter int BLANK_CYC = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NSRC-1:0]           err_vld_i,
  input  logic [8*NSRC-1:0]         err_code_i,
  output logic [NSRC-1:0]           err_gnt_o,
  input  logic                      err_ack_i,
  output logic [7:0]                er_cde_o,
  output logic                      cpu_halt_o,
  output logic                      err_ovf_o,
  output logic [$clog2(DEPTH):0]    err_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2((HOLD_CYC > BLANK_CYC ? HOLD_CYC : BLANK_CYC) + 1);
  typedef enum logic [1:0] {IDLE, SHOW, BLANK} st_t;
  st_t st_q, st_d;
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] head_q, tail_q, disp_q, disp_d, newest_idx, off, head_nx;
  logic [AW:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [7:0] er_q, er_d, gcode;
  logic halt_q, ovf_q, ovf_d;
  logic [NSRC-1:0] nz_gnt, any_gnt;
  logic hit, dup, full, push, pop, nxt_wrap;
  always_comb begin
    nz_gnt = '0;
    any_gnt = '0;
    gcode = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (err_vld_i[i] && err_code_i[8*i +: 8] != 8'h00) begin
        nz_gnt = NSRC'(1) << i;
        gcode = err_code_i[8*i +: 8];
      end
      if (err_vld_i[i]) any_gnt = NSRC'(1) << i;
    end
  end
  // nonzero codes outrank zero-code requests; zero codes are granted only to clear them
  assign err_gnt_o  = rst ? '0 : (|nz_gnt ? nz_gnt : any_gnt);
  assign hit        = !rst && |nz_gnt;
  assign newest_idx = tail_q - 1'b1;
  assign pop        = err_ack_i && cnt_q != '0;
  assign dup        = hit && cnt_q != '0 && gcode == mem_q[newest_idx];
  assign full       = cnt_q == (AW+1)'(DEPTH);
  assign push       = hit && !dup && !(full && !pop);
  assign ovf_d      = ovf_q | (hit && !dup && full && !pop);
  assign cnt_d      = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  assign head_nx    = head_q + 1'b1;
  assign off        = disp_q - head_q;
  assign nxt_wrap   = ({1'b0, off} + (AW+1)'(1)) >= cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      head_q <= '0;
      tail_q <= '0;
      disp_q <= '0;
      cnt_q  <= '0;
      tmr_q  <= '0;
      er_q   <= '0;
      halt_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      head_q <= pop ? head_nx : head_q;
      tail_q <= push ? tail_q + 1'b1 : tail_q;
      disp_q <= disp_d;
      cnt_q  <= cnt_d;
      tmr_q  <= tmr_d;
      er_q   <= er_d;
      halt_q <= cnt_q != '0;
      ovf_q  <= ovf_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[tail_q] <= gcode;
  // an ack always wins over timer expiry and restarts the blank gap toward the new head
  always_comb begin
    st_d = st_q;
    disp_d = disp_q;
    tmr_d = tmr_q;
    case (st_q)
      IDLE: begin
        tmr_d = '0;
        if (cnt_q != '0 && !pop) begin
          st_d = SHOW;
          disp_d = head_q;
        end
      end
      SHOW, BLANK: begin
        if (pop) begin
          st_d = cnt_d != '0 ? BLANK : IDLE;
          disp_d = head_nx;
          tmr_d = '0;
        end else if (st_q == SHOW && tmr_q == TW'(HOLD_CYC - 1)) begin
          tmr_d = '0;
          if (cnt_q > (AW+1)'(1)) begin
            st_d = BLANK;
            disp_d = nxt_wrap ? head_q : disp_q + 1'b1;
          end
        end else if (st_q == BLANK && tmr_q == TW'(BLANK_CYC - 1)) begin
          st_d = SHOW;
          tmr_d = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
  end
  always_comb er_d = st_d == SHOW ? mem_q[disp_d] : 8'h00;
  assign er_cde_o   = er_q;
  assign cpu_halt_o = halt_q;
  assign err_ovf_o  = ovf_q;
  assign err_cnt_o  = cnt_q;
endmodule
